window_address_gen: RTL and testbench
=====================================

// Module: window_address_gen
// PURPOSE
//  Parametrised successor of address_handler: generates read addresses for every n x n window tap over an
//  h x w frame (raster order) and the matching write address per output pixel. Adds border modes, separate
//  src/dst base addresses, start/done/stall handshake, tap framing and a latency-matched write path.
//  It sits between memory and the WOS sorter in Masked2DFilter.
// PARAMETERS
//  WORD      32  address/dimension width
//  MAX_N     25  largest window edge; N_BITS = $clog2(MAX_N+1)
//  PIPE_LAT  4   cycles from last tap read to its write (sorter latency), >=1
// PORTS
//  clk          in   1       clock
//  rst          in   1       asynchronous, active-low reset
//  start        in   1       begin a frame (sampled only in IDLE)
//  stall        in   1       freeze all state, counters and delay line this cycle
//  h, w         in   WORD    frame height/width, latched at start
//  n            in   N_BITS  window edge, latched at start
//  mode         in   2       0 CROP, 1 CLAMP, 2 ZERO (3 = invalid)
//  src_base     in   WORD    input frame base address
//  dst_base     in   WORD    output frame base address
//  r_addr       out  WORD    tap read address
//  r_en         out  1       tap read strobe
//  pad          out  1       tap is zero padding (ZERO mode, r_en=0)
//  tap_first    out  1       first tap of a window
//  tap_last     out  1       last tap of a window
//  w_addr       out  WORD    output write address
//  w_en         out  1       output write strobe
//  busy         out  1       frame in progress
//  done         out  1       one-cycle pulse at frame end
//  err          out  1       start rejected; held until next accepted start
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters and delay line cleared; reset mid-frame aborts without done.
//  - FSM IDLE->READ->DRAIN->DONE->IDLE. start in IDLE with valid config latches inputs and enters READ;
//    start while busy is ignored. Invalid config: n even, n=0, n>MAX_N, mode=3, h=0, w=0, or CROP with
//    n>h or n>w. An invalid start sets err=1 and stays in IDLE.
//  - Timing: start sampled at edge k -> first tap (r_en or pad) registered at edge k+1. One tap per
//    unstalled cycle; no bubbles between windows. The window has n*n taps in row-major order,
//    dy,dx in -(n/2)..+(n/2).
//  - Output pixels are visited in raster order. CROP: y in n/2..h-1-n/2, x likewise; output is
//    (h-n+1) x (w-n+1). CLAMP/ZERO: y in 0..h-1, x in 0..w-1.
//  - Tap coord (yy,xx)=(y+dy,x+dx). CLAMP: clip each to [0,h-1]/[0,w-1]. ZERO out-of-range tap:
//    r_en=0, pad=1, r_addr=0. Otherwise r_addr=src_base+yy*w+xx, r_en=1, pad=0.
//  - tap_first/tap_last mark taps 0 and n*n-1 (coincide when n=1); both valid on pad taps.
//  - w_addr=dst_base+o where o counts outputs 0,1,2,..; w_en registered PIPE_LAT unstalled cycles after
//    the tap_last cycle, through a PIPE_LAT-deep delay line.
//  - READ->DRAIN after the final tap; DRAIN->DONE when the delay line is empty; done=1 for one cycle in
//    DONE, busy=0 there and in IDLE.
//  - stall=1: every register holds, r_en/pad/w_en forced 0 that cycle, then resume identically.
//  - Arithmetic: unsigned WORD-bit, wrapping mod 2^WORD; signed tap offsets use WORD+1 bits before clip.
//    Use incremental row/col address update, no per-tap multiplier.
// STRUCTURE
//  - filter_pkg: MODE_CROP/CLAMP/ZERO codes, FSM state encoding, N_BITS function.
//  - Sub-module addr_delay_line #(WORD, PIPE_LAT): shift register of {valid, addr} with a hold enable.
// TESTING
//  1 h=15 w=10 n=5 CROP, bases 0/150: first taps 0,1,2,3,4,10..44; 66 writes, 1650 reads; w_addr 150..215;
//    done is the cycle after the last w_en.
//  2 n=3 CLAMP, pixel (0,0): r_addr 0,0,1,0,0,1,10,10,11; 150 writes.
//  3 n=3 ZERO, pixel (0,0): pad on taps 0,1,2,3,6 with r_en=0; reads 0,1,10,11 on taps 4,5,7,8.
//  4 n=1 CLAMP: r_addr = w_addr-150 for every pixel, tap_first=tap_last=1, 150 reads and writes.
//  5 stall 3 cycles mid-window and during DRAIN: address sequence identical to run 1, no strobes while
//    stalled, total time +3 per stall.
//  6 n=4 or mode=3 -> err=1, busy=0; rst low mid-frame -> outputs 0 at once; restart runs cleanly.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared definitions for the window address generator:
// border-mode codes, FSM state encoding and width helper.
package filter_pkg;

    localparam logic [1:0] MODE_CROP  = 2'd0;
    localparam logic [1:0] MODE_CLAMP = 2'd1;
    localparam logic [1:0] MODE_ZERO  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic int n_bits(input int max_n);
        return $clog2(max_n + 1);
    endfunction

endpackage

// File: rtl/addr_delay_line.sv
// Fixed-depth {valid, addr} shift register that matches the sorter latency;
// holds its contents whenever en is low.
module addr_delay_line #(
    parameter int WORD     = 32,
    parameter int PIPE_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    input  logic [WORD-1:0] in_addr,
    output logic            out_valid,
    output logic [WORD-1:0] out_addr,
    output logic            pending
);

    // every stage except the output one
    localparam logic [PIPE_LAT-1:0] EARLY =
        PIPE_LAT'((64'd1 << (PIPE_LAT - 1)) - 64'd1);

    logic [PIPE_LAT-1:0] valid_q, valid_d;
    logic [WORD-1:0]     addr_q [PIPE_LAT];
    logic [WORD-1:0]     addr_d [PIPE_LAT];

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (en) begin
            valid_d[0] = in_valid;
            addr_d[0]  = in_valid ? in_addr : '0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                valid_d[i] = valid_q[i-1];
                addr_d[i]  = addr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign out_valid = valid_q[PIPE_LAT-1];
    assign out_addr  = addr_q[PIPE_LAT-1];
    assign pending   = in_valid | (|(valid_q & EARLY));

endmodule

// File: rtl/window_address_gen.sv
// Raster-order n x n window tap address generator with border modes
// and a latency-matched output write path.
module window_address_gen
    import filter_pkg::*;
#(
    parameter int WORD     = 32,
    parameter int MAX_N    = 25,
    parameter int PIPE_LAT = 4,
    parameter int N_BITS   = n_bits(MAX_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic [WORD-1:0]   h,
    input  logic [WORD-1:0]   w,
    input  logic [N_BITS-1:0] n,
    input  logic [1:0]        mode,
    input  logic [WORD-1:0]   src_base,
    input  logic [WORD-1:0]   dst_base,
    output logic [WORD-1:0]   r_addr,
    output logic              r_en,
    output logic              pad,
    output logic              tap_first,
    output logic              tap_last,
    output logic [WORD-1:0]   w_addr,
    output logic              w_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PAD_W = WORD - N_BITS;
    localparam logic [N_BITS-1:0] MAX_N_L = N_BITS'(MAX_N);

    state_e            state_q, state_d;
    logic [WORD-1:0]   h_q, h_d, w_q, w_d;
    logic [N_BITS-1:0] n_q, n_d;
    logic [1:0]        mode_q, mode_d;
    logic [WORD-1:0]   src_q, src_d, dst_q, dst_d;
    logic [WORD-1:0]   y_q, y_d, x_q, x_d;
    logic [N_BITS-1:0] ty_q, ty_d, tx_q, tx_d;
    logic [WORD-1:0]   row_q, row_d, top_q, top_d;
    logic [WORD-1:0]   o_q, o_d;
    logic [WORD-1:0]   r_addr_q, r_addr_d;
    logic              r_en_q, r_en_d, pad_q, pad_d;
    logic              first_q, first_d, last_q, last_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              err_q, err_d;

    logic [WORD-1:0]   half_w, ty_w, tx_w, n_in_w, half_in_w;
    logic [WORD-1:0]   x_lo, x_hi, y_hi, xc;
    logic [N_BITS-1:0] nm1;
    logic signed [WORD:0] yy, xx, yt, hm1, wm1;
    logic              crop, zero, oob, x_neg, x_big;
    logic              row_step, top_step, cfg_bad;
    logic              dl_valid, dl_pending;
    logic [WORD-1:0]   dl_addr;

    assign half_w    = {{PAD_W{1'b0}}, n_q >> 1};
    assign ty_w      = {{PAD_W{1'b0}}, ty_q};
    assign tx_w      = {{PAD_W{1'b0}}, tx_q};
    assign n_in_w    = {{PAD_W{1'b0}}, n};
    assign half_in_w = {{PAD_W{1'b0}}, n >> 1};
    assign nm1       = n_q - 1'b1;
    assign crop      = mode_q == MODE_CROP;
    assign zero      = mode_q == MODE_ZERO;
    assign x_lo      = crop ? half_w : '0;
    assign x_hi      = crop ? w_q - 1'b1 - half_w : w_q - 1'b1;
    assign y_hi      = crop ? h_q - 1'b1 - half_w : h_q - 1'b1;

    // tap coordinates carry a sign bit so borders can be detected
    assign yy  = $signed({1'b0, y_q}) + $signed({1'b0, ty_w})
               - $signed({1'b0, half_w});
    assign xx  = $signed({1'b0, x_q}) + $signed({1'b0, tx_w})
               - $signed({1'b0, half_w});
    assign yt  = $signed({1'b0, y_q}) - $signed({1'b0, half_w});
    assign hm1 = $signed({1'b0, h_q}) - 1;
    assign wm1 = $signed({1'b0, w_q}) - 1;

    assign x_neg = xx[WORD];
    assign x_big = !x_neg && (xx > wm1);
    assign xc    = x_neg ? '0 : (x_big ? w_q - 1'b1 : xx[WORD-1:0]);
    assign oob   = yy[WORD] || (yy > hm1) || x_neg || x_big;

    // clipped row index advances only while inside the frame
    assign row_step = !yy[WORD] && (yy < hm1);
    assign top_step = !yt[WORD] && (yt < hm1);

    assign cfg_bad = !n[0] || (n > MAX_N_L) || (mode == 2'd3)
                   || (h == '0) || (w == '0)
                   || ((mode == MODE_CROP) && ((n_in_w > h) || (n_in_w > w)));

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        w_d      = w_q;
        n_d      = n_q;
        mode_d   = mode_q;
        src_d    = src_q;
        dst_d    = dst_q;
        y_d      = y_q;
        x_d      = x_q;
        ty_d     = ty_q;
        tx_d     = tx_q;
        row_d    = row_q;
        top_d    = top_q;
        o_d      = o_q;
        r_addr_d = r_addr_q;
        r_en_d   = r_en_q;
        pad_d    = pad_q;
        first_d  = first_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        if (!stall) begin
            r_en_d  = 1'b0;
            pad_d   = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b0;
            if (last_q) o_d = o_q + 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (start && cfg_bad) begin
                        err_d = 1'b1;
                    end else if (start) begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_READ;
                        h_d     = h;
                        w_d     = w;
                        n_d     = n;
                        mode_d  = mode;
                        src_d   = src_base;
                        dst_d   = dst_base;
                        y_d     = (mode == MODE_CROP) ? half_in_w : '0;
                        x_d     = (mode == MODE_CROP) ? half_in_w : '0;
                        ty_d    = '0;
                        tx_d    = '0;
                        row_d   = src_base;
                        top_d   = src_base;
                        o_d     = '0;
                    end
                end
                S_READ: begin
                    pad_d    = zero && oob;
                    r_en_d   = !(zero && oob);
                    r_addr_d = (zero && oob) ? '0 : row_q + xc;
                    first_d  = (ty_q == '0) && (tx_q == '0);
                    last_d   = (ty_q == nm1) && (tx_q == nm1);
                    if (tx_q != nm1) begin
                        tx_d = tx_q + 1'b1;
                    end else if (ty_q != nm1) begin
                        tx_d = '0;
                        ty_d = ty_q + 1'b1;
                        if (row_step) row_d = row_q + w_q;
                    end else begin
                        tx_d  = '0;
                        ty_d  = '0;
                        row_d = top_q;
                        if (x_q != x_hi) begin
                            x_d = x_q + 1'b1;
                        end else if (y_q == y_hi) begin
                            state_d = S_DRAIN;
                        end else begin
                            x_d = x_lo;
                            y_d = y_q + 1'b1;
                            if (top_step) begin
                                top_d = top_q + w_q;
                                row_d = top_q + w_q;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!dl_pending) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            w_q      <= '0;
            n_q      <= '0;
            mode_q   <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            y_q      <= '0;
            x_q      <= '0;
            ty_q     <= '0;
            tx_q     <= '0;
            row_q    <= '0;
            top_q    <= '0;
            o_q      <= '0;
            r_addr_q <= '0;
            r_en_q   <= 1'b0;
            pad_q    <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            w_q      <= w_d;
            n_q      <= n_d;
            mode_q   <= mode_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            y_q      <= y_d;
            x_q      <= x_d;
            ty_q     <= ty_d;
            tx_q     <= tx_d;
            row_q    <= row_d;
            top_q    <= top_d;
            o_q      <= o_d;
            r_addr_q <= r_addr_d;
            r_en_q   <= r_en_d;
            pad_q    <= pad_d;
            first_q  <= first_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    addr_delay_line #(
        .WORD     (WORD),
        .PIPE_LAT (PIPE_LAT)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .en        (!stall),
        .in_valid  (last_q),
        .in_addr   (dst_q + o_q),
        .out_valid (dl_valid),
        .out_addr  (dl_addr),
        .pending   (dl_pending)
    );

    assign r_addr    = r_addr_q;
    assign r_en      = r_en_q & ~stall;
    assign pad       = pad_q & ~stall;
    assign tap_first = first_q;
    assign tap_last  = last_q;
    assign w_addr    = dl_addr;
    assign w_en      = dl_valid & ~stall;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_window_address_gen.sv
// Randomized scoreboard bench for window_address_gen against a
// loop-over-pixels reference model.
module tb_window_address_gen;

    localparam int PIPE_LAT = 4;

    logic        clk = 1'b0;
    logic        rst, start, stall;
    logic [31:0] h, w, src_base, dst_base;
    logic [4:0]  n;
    logic [1:0]  mode;
    logic [31:0] r_addr, w_addr;
    logic        r_en, pad, tap_first, tap_last, w_en, busy, done, err;

    typedef struct packed {
        logic [31:0] a;
        logic        p;
        logic        f;
        logic        l;
    } tap_t;

    tap_t        tap_q[$];
    logic [31:0] wr_q[$];
    int          due_q[$];
    int          ucnt, rd_seen, wr_seen;
    int          pass_cnt, chk_cnt;
    bit          mon_en;

    window_address_gen #(.PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .h(h), .w(w), .n(n), .mode(mode),
        .src_base(src_base), .dst_base(dst_base),
        .r_addr(r_addr), .r_en(r_en), .pad(pad),
        .tap_first(tap_first), .tap_last(tap_last),
        .w_addr(w_addr), .w_en(w_en), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    // expected taps and writes straight from the window definition
    task automatic build(input int ih, input int iw, input int in_,
                         input int im, input logic [31:0] s,
                         input logic [31:0] d);
        int half, y0, y1, x0, x1, o;
        longint yy, xx, v;
        tap_t t;
        half = in_ / 2;
        y0 = (im == 0) ? half : 0;
        y1 = (im == 0) ? ih - 1 - half : ih - 1;
        x0 = (im == 0) ? half : 0;
        x1 = (im == 0) ? iw - 1 - half : iw - 1;
        o = 0;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                for (int dy = -half; dy <= half; dy++)
                    for (int dx = -half; dx <= half; dx++) begin
                        yy = y + dy;
                        xx = x + dx;
                        t.f = (dy == -half) && (dx == -half);
                        t.l = (dy == half) && (dx == half);
                        if (im == 2 && (yy < 0 || yy >= ih || xx < 0 || xx >= iw)) begin
                            t.a = '0;
                            t.p = 1'b1;
                        end else begin
                            if (yy < 0) yy = 0;
                            if (yy > ih - 1) yy = ih - 1;
                            if (xx < 0) xx = 0;
                            if (xx > iw - 1) xx = iw - 1;
                            v = longint'(s) + yy * iw + xx;
                            t.a = v[31:0];
                            t.p = 1'b0;
                        end
                        tap_q.push_back(t);
                    end
                wr_q.push_back(d + 32'(o));
                o++;
            end
    endtask

    always @(negedge clk) begin
        tap_t t;
        logic [35:0] e;
        if (mon_en) begin
            if (stall) chk("stall_quiet", {61'd0, r_en, pad, w_en}, 64'd0);
            else ucnt++;
            if (r_en || pad) begin
                rd_seen++;
                if (tap_q.size() == 0) begin
                    chk("extra_tap", 64'd1, 64'd0);
                end else begin
                    t = tap_q.pop_front();
                    e = {t.a, ~t.p, t.p, t.f, t.l};
                    chk("tap", {28'd0, r_addr, r_en, pad, tap_first, tap_last},
                        {28'd0, e});
                    if (t.l) due_q.push_back(ucnt + PIPE_LAT);
                end
            end
            if (w_en) begin
                wr_seen++;
                if (wr_q.size() == 0) begin
                    chk("extra_write", 64'd1, 64'd0);
                end else begin
                    chk("w_addr", {32'd0, w_addr}, {32'd0, wr_q.pop_front()});
                    if (due_q.size() != 0)
                        chk("w_latency", 64'(ucnt), 64'(due_q.pop_front()));
                end
            end
        end
    end

    task automatic run_frame(input int ih, input int iw, input int in_,
                             input int im, input logic [31:0] s,
                             input logic [31:0] d, input int sp,
                             output int taps);
        int cnt, exp_edges;
        bit got;
        tap_q.delete();
        wr_q.delete();
        due_q.delete();
        build(ih, iw, in_, im, s, d);
        taps = tap_q.size();
        exp_edges = taps + PIPE_LAT + 1;
        rd_seen = 0;
        wr_seen = 0;
        @(posedge clk);
        #1;
        h = 32'(ih); w = 32'(iw); n = 5'(in_); mode = 2'(im);
        src_base = s; dst_base = d; start = 1'b1; stall = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start", {63'd0, busy}, 64'd1);
        chk("err_clear", {63'd0, err}, 64'd0);
        cnt = 0;
        got = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            stall = ($urandom_range(99) < sp);
            @(posedge clk);
            if (!stall) cnt++;
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        stall = 1'b0;
        if (!got) chk("timeout", 64'd0, 64'd1);
        chk("edges", 64'(cnt), 64'(exp_edges));
        chk("busy_done", {63'd0, busy}, 64'd0);
        chk("taps_left", 64'(tap_q.size()), 64'd0);
        chk("writes_left", 64'(wr_q.size()), 64'd0);
        chk("reads_seen", 64'(rd_seen), 64'(taps));
        @(posedge clk);
        #1;
        chk("done_pulse", {63'd0, done}, 64'd0);
    endtask

    task automatic try_bad(input int ih, input int iw, input int in_,
                           input int im);
        @(posedge clk);
        #1;
        h = 32'(ih); w = 32'(iw); n = 5'(in_); mode = 2'(im);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("err_set", {62'd0, err, busy}, 64'd2);
        @(posedge clk);
        #1;
        chk("err_hold", {62'd0, err, busy}, 64'd2);
    endtask

    initial begin
        int taps, ih, iw, in_, im;
        pass_cnt = 0; chk_cnt = 0; ucnt = 0;
        mon_en = 1'b0;
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        h = '0; w = '0; n = '0; mode = '0; src_base = '0; dst_base = '0;
        #12;
        chk("reset_addr", {r_addr, w_addr}, 64'd0);
        chk("reset_flags", {56'd0, r_en, pad, tap_first, tap_last, w_en, busy, done, err}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;

        run_frame(15, 10, 5, 0, 32'd0, 32'd150, 0, taps);
        chk("crop_reads", 64'(rd_seen), 64'd1650);
        chk("crop_writes", 64'(wr_seen), 64'd66);
        run_frame(15, 10, 5, 0, 32'd0, 32'd150, 12, taps);
        run_frame(15, 10, 3, 1, 32'd0, 32'd150, 0, taps);
        chk("clamp_writes", 64'(wr_seen), 64'd150);
        run_frame(15, 10, 3, 2, 32'd0, 32'd150, 8, taps);
        run_frame(15, 10, 1, 1, 32'd0, 32'd150, 8, taps);
        chk("n1_reads", 64'(rd_seen), 64'd150);

        try_bad(15, 10, 4, 1);
        try_bad(15, 10, 3, 3);
        try_bad(0, 10, 3, 1);
        try_bad(4, 10, 5, 0);

        for (int k = 0; k < 16; k++) begin
            ih = $urandom_range(6, 1);
            iw = $urandom_range(6, 1);
            in_ = 2 * $urandom_range(3, 0) + 1;
            im = $urandom_range(2, 0);
            if (im == 0 && (in_ > ih || in_ > iw))
                try_bad(ih, iw, in_, im);
            else
                run_frame(ih, iw, in_, im, $urandom, $urandom, 10, taps);
        end

        // abort a frame with reset, then confirm a clean restart
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        h = 32'd15; w = 32'd10; n = 5'd3; mode = 2'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_addr", {r_addr, w_addr}, 64'd0);
        chk("abort_flags", {56'd0, r_en, pad, tap_first, tap_last, w_en, busy, done, err}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        run_frame(7, 9, 3, 2, 32'h1000, 32'h2000, 10, taps);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
